mem_port_arbiter: RTL and testbench

//  Two-requester arbiter and sequencer for the single-port byte-addressed data RAM.

---
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester round-robin arbiter and sequencer for a
//               single-port, byte-addressed data RAM.
//               Requester 0 is the CPU (cpu_mfa / cpu_mfc four-phase handshake).
//               Requester 1 is the loader/debug port (ld_req / ld_ack).
//               The winner's command is latched at grant and driven to the RAM
//               for WAIT_STATES+1 cycles. Read data is zero-extended and
//               returned, followed by a registered completion handshake.
//               Misaligned or reserved accesses bypass the RAM and complete
//               with err=1 and zero read data.
// Ports       : CLK, Reset (async, active-low)
//               cpu_*  : CPU request / command / read data / mfc
//               ld_*   : loader request / command / read data / ack
//               ram_*  : RAM enable (active-low), command, write / read data
//               err    : error flag for the current completion
//               gnt    : one-hot grant {ld, cpu}, 00 when idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    // CPU requester
    input  logic              cpu_mfa,
    input  logic              cpu_rw,
    input  logic [1:0]        cpu_type,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_mfc,
    // Loader requester
    input  logic              ld_req,
    input  logic              ld_rw,
    input  logic [1:0]        ld_type,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_wdata,
    output logic [31:0]       ld_rdata,
    output logic              ld_ack,
    // RAM side
    output logic              ram_en_n,
    output logic              ram_rw,
    output logic [1:0]        ram_type,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    // Status
    output logic              err,
    output logic [1:0]        gnt
);

    localparam int              CNT_W      = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WAIT_STATES);
    localparam logic [1:0]      C_T_BYTE   = 2'b00;
    localparam logic [1:0]      C_T_HALF   = 2'b01;
    localparam logic [1:0]      C_T_WORD   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last_ld;   // 1: loader was granted most recently
    logic               r_err_pend;  // error grant waiting to raise its completion
    logic [CNT_W-1:0]   r_count;

    logic               w_any_req;
    logic               w_pick_ld;
    logic               w_sel_rw;
    logic [1:0]         w_sel_type;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic               w_sel_bad;
    logic               w_granted_req;
    logic [31:0]        w_rd_ext;

    always_comb begin
        w_any_req   = cpu_mfa | ld_req;
        // Loader wins when it is alone, or on a tie when the CPU went last.
        w_pick_ld   = ld_req & (~cpu_mfa | ~r_last_ld);
        w_sel_rw    = w_pick_ld ? ld_rw    : cpu_rw;
        w_sel_type  = w_pick_ld ? ld_type  : cpu_type;
        w_sel_addr  = w_pick_ld ? ld_addr  : cpu_addr;
        w_sel_wdata = w_pick_ld ? ld_wdata : cpu_wdata;

        case (w_sel_type)
            C_T_BYTE: w_sel_bad = 1'b0;
            C_T_HALF: w_sel_bad = w_sel_addr[0];
            C_T_WORD: w_sel_bad = |w_sel_addr[1:0];
            default:  w_sel_bad = 1'b1;
        endcase

        w_granted_req = gnt[1] ? ld_req : cpu_mfa;

        // RAM returns right-justified data; only the accessed bytes are kept.
        case (ram_type)
            C_T_BYTE: w_rd_ext = {24'd0, ram_rdata[7:0]};
            C_T_HALF: w_rd_ext = {16'd0, ram_rdata[15:0]};
            default:  w_rd_ext = ram_rdata;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_state    <= S_IDLE;
            r_last_ld  <= 1'b1;
            r_err_pend <= 1'b0;
            r_count    <= '0;
            cpu_rdata  <= '0;
            cpu_mfc    <= 1'b0;
            ld_rdata   <= '0;
            ld_ack     <= 1'b0;
            ram_en_n   <= 1'b1;
            ram_rw     <= 1'b0;
            ram_type   <= 2'b00;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            err        <= 1'b0;
            gnt        <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        gnt       <= w_pick_ld ? 2'b10 : 2'b01;
                        r_last_ld <= w_pick_ld;
                        r_count   <= '0;
                        if (w_sel_bad) begin
                            // RAM command registers keep their previous values.
                            r_err_pend <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            ram_rw    <= w_sel_rw;
                            ram_type  <= w_sel_type;
                            ram_addr  <= w_sel_addr;
                            ram_wdata <= w_sel_wdata;
                            ram_en_n  <= 1'b0;
                            r_state   <= S_ACCESS;
                        end
                    end
                end

                S_ACCESS: begin
                    if (r_count == C_LAST_CNT) begin
                        ram_en_n <= 1'b1;
                        r_state  <= S_DONE;
                        if (gnt[1]) begin
                            ld_ack <= 1'b1;
                            if (!ram_rw) ld_rdata <= w_rd_ext;
                        end else begin
                            cpu_mfc <= 1'b1;
                            if (!ram_rw) cpu_rdata <= w_rd_ext;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end

                S_DONE: begin
                    if (r_err_pend) begin
                        // Error completion is raised one edge after the grant.
                        r_err_pend <= 1'b0;
                        err        <= 1'b1;
                        if (gnt[1]) begin
                            ld_ack   <= 1'b1;
                            ld_rdata <= '0;
                        end else begin
                            cpu_mfc   <= 1'b1;
                            cpu_rdata <= '0;
                        end
                    end else if (!w_granted_req) begin
                        cpu_mfc <= 1'b0;
                        ld_ack  <= 1'b0;
                        err     <= 1'b0;
                        gnt     <= 2'b00;
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state  <= S_IDLE;
                    ram_en_n <= 1'b1;
                    gnt      <= 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a big-endian
//               byte-addressed RAM model. Stimulus pushes expected completions
//               and direct observations into queues; a monitor process pops
//               and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int WS = 1;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        cpu_mfa, cpu_rw, cpu_mfc;
    logic [1:0]  cpu_type;
    logic [7:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ld_req, ld_rw, ld_ack;
    logic [1:0]  ld_type;
    logic [7:0]  ld_addr;
    logic [31:0] ld_wdata, ld_rdata;
    logic        ram_en_n, ram_rw, err;
    logic [1:0]  ram_type, gnt;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    mem_port_arbiter #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
        .CLK(CLK), .Reset(Reset),
        .cpu_mfa(cpu_mfa), .cpu_rw(cpu_rw), .cpu_type(cpu_type), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_mfc(cpu_mfc),
        .ld_req(ld_req), .ld_rw(ld_rw), .ld_type(ld_type), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_ack(ld_ack),
        .ram_en_n(ram_en_n), .ram_rw(ram_rw), .ram_type(ram_type), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .err(err), .gnt(gnt)
    );

    always #5 CLK = ~CLK;

    // ---------------- RAM model (big-endian, right-justified data) ----------
    logic [7:0] mem [0:255];
    logic [7:0] a1, a2, a3;

    always_comb begin
        a1 = ram_addr + 8'd1;
        a2 = ram_addr + 8'd2;
        a3 = ram_addr + 8'd3;
        // Upper lanes carry junk so that zero-extension is observable.
        case (ram_type)
            2'b00:   ram_rdata = {24'hA5A5A5, mem[ram_addr]};
            2'b01:   ram_rdata = {16'hA5A5, mem[ram_addr], mem[a1]};
            2'b10:   ram_rdata = {mem[ram_addr], mem[a1], mem[a2], mem[a3]};
            default: ram_rdata = 32'hA5A5A5A5;
        endcase
    end

    always @(posedge CLK) begin
        if (!ram_en_n && ram_rw) begin
            case (ram_type)
                2'b00: mem[ram_addr] <= ram_wdata[7:0];
                2'b01: begin mem[ram_addr] <= ram_wdata[15:8]; mem[a1] <= ram_wdata[7:0]; end
                2'b10: begin
                    mem[ram_addr] <= ram_wdata[31:24]; mem[a1] <= ram_wdata[23:16];
                    mem[a2]       <= ram_wdata[15:8];  mem[a3] <= ram_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    int en_total = 0;
    always @(posedge CLK) if (!ram_en_n) en_total <= en_total + 1;

    // ---------------- scoreboard queues -----------------------------------
    logic [31:0] c_rd_q[$], l_rd_q[$];
    logic        c_err_q[$], l_err_q[$];
    logic        c_chk_q[$], l_chk_q[$];
    int          ord_q[$];
    string       d_name[$];
    logic [31:0] d_act[$], d_exp[$];

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  end_req = 1'b0;
    bit  end_done = 1'b0;

    function automatic void dchk(string nm, logic [31:0] a, logic [31:0] e);
        d_name.push_back(nm);
        d_act.push_back(a);
        d_exp.push_back(e);
    endfunction

    // ---------------- monitor ---------------------------------------------
    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", nm, a, e);
        end
    endfunction

    function automatic void complete(bit who);
        logic [31:0] rd;
        logic        er, ck;
        int          o;
        if ((who ? l_rd_q.size() : c_rd_q.size()) == 0 || ord_q.size() == 0) begin
            chk(who ? "ld_unexpected_ack" : "cpu_unexpected_mfc", 32'd1, 32'd0);
        end else begin
            if (who) begin
                rd = l_rd_q.pop_front(); er = l_err_q.pop_front(); ck = l_chk_q.pop_front();
            end else begin
                rd = c_rd_q.pop_front(); er = c_err_q.pop_front(); ck = c_chk_q.pop_front();
            end
            o = ord_q.pop_front();
            chk("completion_order", {31'd0, who}, 32'(o));
            chk(who ? "ld_gnt" : "cpu_gnt", {30'd0, gnt}, who ? 32'd2 : 32'd1);
            chk(who ? "ld_err" : "cpu_err", {31'd0, err}, {31'd0, er});
            if (ck) chk(who ? "ld_rdata" : "cpu_rdata", who ? ld_rdata : cpu_rdata, rd);
        end
    endfunction

    initial begin : monitor
        logic prev_mfc, prev_ack;
        prev_mfc = 1'b0;
        prev_ack = 1'b0;
        forever begin
            @(negedge CLK);
            while (d_name.size() > 0)
                chk(d_name.pop_front(), d_act.pop_front(), d_exp.pop_front());
            if (cpu_mfc && !prev_mfc) complete(1'b0);
            if (ld_ack && !prev_ack) complete(1'b1);
            prev_mfc = cpu_mfc;
            prev_ack = ld_ack;
            if (end_req && !end_done) begin
                chk("unserved_expectations",
                    32'(c_rd_q.size() + l_rd_q.size() + ord_q.size()), 32'd0);
                end_done = 1'b1;
            end
        end
    end

    // ---------------- transaction driver ----------------------------------
    // Called at a negedge; returns at the negedge after the handshake closed.
    task automatic txn(input bit who, input logic rw, input logic [1:0] t,
                       input logic [7:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int hold,
                       output int lat, output int en_used);
        int e0;
        bit seen;
        if (who) begin
            l_rd_q.push_back(erd); l_err_q.push_back(eerr); l_chk_q.push_back(!rw || eerr);
            ld_rw = rw; ld_type = t; ld_addr = a; ld_wdata = wd; ld_req = 1'b1;
        end else begin
            c_rd_q.push_back(erd); c_err_q.push_back(eerr); c_chk_q.push_back(!rw || eerr);
            cpu_rw = rw; cpu_type = t; cpu_addr = a; cpu_wdata = wd; cpu_mfa = 1'b1;
        end
        e0   = en_total;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            lat++;
            seen = who ? ld_ack : cpu_mfc;
        end
        if (!seen) dchk("handshake_timeout", 32'd0, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            dchk("hold_complete_high", {31'd0, (who ? ld_ack : cpu_mfc)}, 32'd1);
        end
        if (who) ld_req = 1'b0; else cpu_mfa = 1'b0;
        @(negedge CLK);
        dchk("complete_drops_next_edge", {31'd0, (who ? ld_ack : cpu_mfc)}, 32'd0);
        en_used = en_total - e0;
    endtask

    // ---------------- stimulus --------------------------------------------
    initial begin : stim
        int  lat, en, lat_a, en_a, lat_b, en_b;
        bit  seen;
        Reset = 1'b0;
        cpu_mfa = 1'b0; cpu_rw = 1'b0; cpu_type = 2'b00; cpu_addr = 8'h00; cpu_wdata = 32'h0;
        ld_req  = 1'b0; ld_rw  = 1'b0; ld_type  = 2'b00; ld_addr  = 8'h00; ld_wdata  = 32'h0;

        // Reset state
        repeat (2) @(negedge CLK);
        dchk("rst_ram_en_n", {31'd0, ram_en_n}, 32'd1);
        dchk("rst_cpu_mfc",  {31'd0, cpu_mfc}, 32'd0);
        dchk("rst_ld_ack",   {31'd0, ld_ack}, 32'd0);
        dchk("rst_gnt",      {30'd0, gnt}, 32'd0);
        dchk("rst_err",      {31'd0, err}, 32'd0);
        dchk("rst_cpu_rdata", cpu_rdata, 32'd0);
        dchk("rst_ld_rdata",  ld_rdata, 32'd0);
        dchk("rst_ram_cmd",  {21'd0, ram_rw, ram_type, ram_addr}, 32'd0);
        dchk("rst_ram_wdata", ram_wdata, 32'd0);
        Reset = 1'b1;
        @(negedge CLK);

        // CPU word write then read at 0x10
        ord_q.push_back(0);
        txn(1'b0, 1'b1, 2'b10, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, lat, en);
        dchk("wr_latency", 32'(lat), 32'(WS + 2));
        dchk("wr_en_cycles", 32'(en), 32'(WS + 1));
        ord_q.push_back(0);
        txn(1'b0, 1'b0, 2'b10, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, lat, en);
        dchk("rd_latency", 32'(lat), 32'(WS + 2));
        dchk("rd_en_cycles", 32'(en), 32'(WS + 1));

        // Alignment errors: misaligned word, reserved type, misaligned half
        ord_q.push_back(0);
        txn(1'b0, 1'b0, 2'b10, 8'h02, 32'h0, 32'h0, 1'b1, 0, lat, en);
        dchk("err_word_latency", 32'(lat), 32'd2);
        dchk("err_word_no_ram", 32'(en), 32'd0);
        ord_q.push_back(0);
        txn(1'b0, 1'b0, 2'b11, 8'h00, 32'h0, 32'h0, 1'b1, 0, lat, en);
        dchk("err_type_latency", 32'(lat), 32'd2);
        dchk("err_type_no_ram", 32'(en), 32'd0);
        ord_q.push_back(1);
        txn(1'b1, 1'b1, 2'b01, 8'h01, 32'h1234, 32'h0, 1'b1, 0, lat, en);
        dchk("err_half_no_ram", 32'(en), 32'd0);

        // Loader word write, byte and halfword reads
        ord_q.push_back(1);
        txn(1'b1, 1'b1, 2'b10, 8'h10, 32'h11223344, 32'h0, 1'b0, 0, lat, en);
        dchk("ld_wr_latency", 32'(lat), 32'(WS + 2));
        ord_q.push_back(1);
        txn(1'b1, 1'b0, 2'b00, 8'h13, 32'h0, 32'h00000044, 1'b0, 0, lat, en);
        ord_q.push_back(1);
        txn(1'b1, 1'b0, 2'b01, 8'h12, 32'h0, 32'h00003344, 1'b0, 0, lat, en);

        // CPU holds mfa five cycles after mfc
        ord_q.push_back(0);
        txn(1'b0, 1'b0, 2'b10, 8'h10, 32'h0, 32'h11223344, 1'b0, 5, lat, en);
        dchk("hold_single_access", 32'(en), 32'(WS + 1));
        dchk("hold_back_idle_gnt", {30'd0, gnt}, 32'd0);

        // Reset asserted in the middle of an access
        cpu_rw = 1'b0; cpu_type = 2'b10; cpu_addr = 8'h10; cpu_mfa = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            seen = !ram_en_n;
        end
        dchk("midreset_access_started", {31'd0, seen}, 32'd1);
        #2 Reset = 1'b0;
        #1;
        dchk("midreset_ram_en_n", {31'd0, ram_en_n}, 32'd1);
        dchk("midreset_cpu_mfc",  {31'd0, cpu_mfc}, 32'd0);
        dchk("midreset_gnt",      {30'd0, gnt}, 32'd0);
        cpu_mfa = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);

        // Three consecutive tie rounds: CPU, LD, CPU, then the leftover LD
        ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1);
        fork
            begin
                txn(1'b0, 1'b0, 2'b10, 8'h10, 32'h0, 32'h11223344, 1'b0, 0, lat_a, en_a);
                txn(1'b0, 1'b1, 2'b00, 8'h20, 32'h0000005A, 32'h0, 1'b0, 0, lat_a, en_a);
            end
            begin
                txn(1'b1, 1'b0, 2'b00, 8'h10, 32'h0, 32'h00000011, 1'b0, 0, lat_b, en_b);
                txn(1'b1, 1'b0, 2'b00, 8'h20, 32'h0, 32'h0000005A, 1'b0, 0, lat_b, en_b);
            end
        join

        repeat (2) @(negedge CLK);
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_done; i++) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
`default_nettype wire
